// File: rtl/spi_pkg.sv
// Shared types for the SPI read master: FSM state encoding and SPI mode constants.
package spi_pkg;

  typedef enum logic [2:0] {
    GUARD = 3'd0,
    IDLE  = 3'd1,
    SETUP = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_e;

  // {CPOL,CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period divider and SCLK generator; hp_tick pulses once every CLK_DIV clks while enabled.
// SCLK is a plain register output, parked at the idle level whenever run_i is low.
module spi_clk_gen #(
  parameter int CLK_DIV  = 26,
  parameter bit IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst_l,
  input  logic en_i,
  input  logic clr_i,
  input  logic run_i,
  output logic hp_tick_o,
  output logic sclk_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] cnt_q;
  logic             sclk_q;

  assign hp_tick_o = en_i && !clr_i && (cnt_q == DIV_W'(CLK_DIV - 1));
  assign sclk_o    = sclk_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q  <= '0;
      sclk_q <= IDLE_LVL;
    end else begin
      if (clr_i || hp_tick_o) begin
        cnt_q <= '0;
      end else if (en_i) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (!run_i) begin
        sclk_q <= IDLE_LVL;
      end else if (hp_tick_o) begin
        sclk_q <= ~sclk_q;
      end
    end
  end

endmodule

// File: rtl/spi_read_master.sv
// SPI read-only master: one DATA_W word per rd request, d_ready held until rd drops.
// Latency (2*DATA_W+2)*CLK_DIV clks from acceptance; CS-high guard of GUARD_HP half-periods between words.
module spi_read_master
  import spi_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int CLK_DIV  = 26,
  parameter int N_CS     = 1,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0,
  parameter int GUARD_HP = 22,
  parameter int CH_W     = 1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              sdo,
  output logic              sclk,
  output logic [N_CS-1:0]   cs_n,
  input  logic              rd,
  input  logic [CH_W-1:0]   ch,
  output logic              busy,
  output logic              d_ready,
  output logic [DATA_W-1:0] d
);

  localparam logic [1:0] MODE         = {1'(CPOL), 1'(CPHA)};
  localparam logic       IDLE_LVL     = MODE[1];
  localparam logic       SAMPLE_TRAIL = (MODE == MODE1) || (MODE == MODE3);
  localparam int         GRD_W        = $clog2(GUARD_HP + 1);
  localparam int         BIT_W        = $clog2(DATA_W + 1);

  state_e              state_q;
  logic [GRD_W-1:0]    guard_q;
  logic [BIT_W-1:0]    bit_q;
  logic [DATA_W-1:0]   sh_q;
  logic [DATA_W-1:0]   d_q;
  logic [N_CS-1:0]     cs_n_q;
  logic                busy_q;
  logic                drdy_q;
  logic                hp_tick;
  logic                accept;
  logic                trailing;
  logic                sample;

  assign accept   = (state_q == IDLE) && rd && (32'(ch) < N_CS);
  assign trailing = (sclk != IDLE_LVL);
  assign sample   = (state_q == SHIFT) && hp_tick && (trailing == SAMPLE_TRAIL);

  assign cs_n    = cs_n_q;
  assign busy    = busy_q;
  assign d_ready = drdy_q;
  assign d       = d_q;

  spi_clk_gen #(
    .CLK_DIV  (CLK_DIV),
    .IDLE_LVL (IDLE_LVL)
  ) u_clk_gen (
    .clk       (clk),
    .rst_l     (rst_l),
    .en_i      (state_q != IDLE),
    .clr_i     (accept),
    .run_i     (state_q == SHIFT),
    .hp_tick_o (hp_tick),
    .sclk_o    (sclk)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= GUARD;
      guard_q <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      d_q     <= '0;
      cs_n_q  <= '1;
      busy_q  <= 1'b1;
      drdy_q  <= 1'b0;
    end else begin
      case (state_q)
        GUARD: if (hp_tick) begin
          if (guard_q == GRD_W'(GUARD_HP - 1)) begin
            guard_q <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            guard_q <= guard_q + 1'b1;
          end
        end
        IDLE: if (accept) begin
          cs_n_q  <= ~(N_CS'(1) << ch);
          busy_q  <= 1'b1;
          bit_q   <= BIT_W'(DATA_W);
          state_q <= SETUP;
        end
        SETUP: if (hp_tick) state_q <= SHIFT;
        SHIFT: if (hp_tick) begin
          if (sample) begin
            sh_q  <= {sh_q[DATA_W-2:0], sdo};
            bit_q <= bit_q - 1'b1;
          end
          // The final edge is always a trailing one; with CPHA=1 it also takes the last bit.
          if (trailing && (bit_q == BIT_W'(SAMPLE_TRAIL))) state_q <= HOLD;
        end
        HOLD: if (hp_tick) begin
          d_q     <= sh_q;
          drdy_q  <= 1'b1;
          cs_n_q  <= '1;
          state_q <= DONE;
        end
        DONE: if (!rd) begin
          drdy_q  <= 1'b0;
          guard_q <= '0;
          state_q <= GUARD;
        end
        default: begin
          cs_n_q  <= '1;
          drdy_q  <= 1'b0;
          busy_q  <= 1'b1;
          guard_q <= '0;
          state_q <= GUARD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_read_master.sv
// Directed bench: five masters (modes 0..3 at 16 bits, mode 0 at 12 bits) each with a behavioural slave.
module tb_spi_read_master;

  localparam int NI  = 5;
  localparam int DIV = 4;
  localparam int GHP = 3;
  localparam int DW_A   [NI] = '{16, 16, 16, 16, 12};
  localparam int CPOL_A [NI] = '{0, 0, 1, 1, 0};
  localparam int CPHA_A [NI] = '{0, 1, 0, 1, 0};

  logic        clk   = 1'b0;
  logic        rst_l = 1'b0;
  logic        rd_a   [NI];
  logic [2:0]  ch_a   [NI];
  logic [15:0] word_a [NI];
  wire         sclk_a [NI];
  wire         busy_a [NI];
  wire         drdy_a [NI];
  wire  [3:0]  csn_a  [NI];
  wire  [15:0] d_a    [NI];
  wire  [31:0] edg_a  [NI];
  wire  [31:0] csf_a  [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int DW = DW_A[g];
    logic [DW-1:0] d_loc;
    logic          sdo    = 1'b0;
    logic [31:0]   edg    = '0;
    logic [31:0]   csf    = '0;
    logic          sel_p  = 1'b0;
    logic          sclk_p = 1'(CPOL_A[g]);

    spi_read_master #(
      .DATA_W(DW), .CLK_DIV(DIV), .N_CS(4), .CPOL(CPOL_A[g]), .CPHA(CPHA_A[g]),
      .GUARD_HP(GHP), .CH_W(3)
    ) u_dut (
      .clk(clk), .rst_l(rst_l), .sdo(sdo), .sclk(sclk_a[g]), .cs_n(csn_a[g]),
      .rd(rd_a[g]), .ch(ch_a[g]), .busy(busy_a[g]), .d_ready(drdy_a[g]), .d(d_loc)
    );

    assign d_a[g]   = 16'(d_loc);
    assign edg_a[g] = edg;
    assign csf_a[g] = csf;

    // Slave: counts SCLK edges while selected and presents bit k of the word, MSB first.
    always @(negedge clk) begin : slave
      logic        sel;
      int          k;
      logic [15:0] w;
      sel = ~&csn_a[g];
      if (sel && !sel_p) begin
        edg = '0;
        csf = csf + 1;
      end else if (sel && (sclk_a[g] != sclk_p)) begin
        edg = edg + 1;
      end
      sel_p  = sel;
      sclk_p = sclk_a[g];
      k = (CPHA_A[g] != 0) ? (int'(edg) - 1) / 2 : int'(edg) / 2;
      if (CPHA_A[g] != 0 && edg == 0) begin
        sdo = 1'b0;
      end else if (k < DW) begin
        w   = word_a[g] >> (DW - 1 - k);
        sdo = w[0];
      end else begin
        sdo = 1'b0;
      end
    end
  end

  task automatic wait_idle(input int g, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy_a[g] === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Starts at a negedge; lat = clks from acceptance edge to d_ready, -1 on timeout. rd stays high.
  task automatic run_xfer(input int g, input logic [2:0] c, input logic [15:0] w, output int lat);
    word_a[g] = w;
    ch_a[g]   = c;
    rd_a[g]   = 1'b1;
    lat       = -1;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk);
      #1;
      if (drdy_a[g] === 1'b1) begin
        lat = i - 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      checks++; if (csn_a[g] !== 4'hF) begin errors++; $display("FAIL reset_cs_n[%0d] got %h exp f", g, csn_a[g]); end
      checks++; if (sclk_a[g] !== 1'(CPOL_A[g])) begin errors++; $display("FAIL reset_sclk[%0d] got %b exp %0d", g, sclk_a[g], CPOL_A[g]); end
      checks++; if (d_a[g] !== 16'h0) begin errors++; $display("FAIL reset_d[%0d] got %h exp 0", g, d_a[g]); end
      checks++; if (drdy_a[g] !== 1'b0) begin errors++; $display("FAIL reset_d_ready[%0d] got %b exp 0", g, drdy_a[g]); end
      checks++; if (busy_a[g] !== 1'b1) begin errors++; $display("FAIL reset_busy[%0d] got %b exp 1", g, busy_a[g]); end
    end
    @(negedge clk);
    rst_l = 1'b1;
    repeat (GHP * DIV - 1) @(posedge clk);
    #1;
    checks++; if (busy_a[0] !== 1'b1) begin errors++; $display("FAIL guard_busy got %b exp 1", busy_a[0]); end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      checks++; if (busy_a[g] !== 1'b0) begin errors++; $display("FAIL idle_busy[%0d] got %b exp 0", g, busy_a[g]); end
    end
  endtask

  task automatic test_mode0;
    bit ok;
    int lat;
    int c0;
    wait_idle(0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL m0_idle got timeout exp idle"); end
    c0 = int'(csf_a[0]);
    run_xfer(0, 3'd0, 16'hA5C3, lat);
    checks++; if (lat < 135 || lat > 137) begin errors++; $display("FAIL m0_latency got %0d exp 136", lat); end
    checks++; if (d_a[0] !== 16'hA5C3) begin errors++; $display("FAIL m0_data got %h exp a5c3", d_a[0]); end
    checks++; if (edg_a[0] !== 32'd32) begin errors++; $display("FAIL m0_edges got %0d exp 32", edg_a[0]); end
    checks++; if (int'(csf_a[0]) - c0 != 1) begin errors++; $display("FAIL m0_cs_falls got %0d exp 1", int'(csf_a[0]) - c0); end
    checks++; if (csn_a[0] !== 4'hF) begin errors++; $display("FAIL m0_cs_release got %h exp f", csn_a[0]); end
    @(negedge clk);
    rd_a[0] = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (drdy_a[0] !== 1'b0) begin errors++; $display("FAIL m0_drdy_drop got %b exp 0", drdy_a[0]); end
  endtask

  task automatic test_modes;
    bit ok;
    int lat;
    for (int g = 1; g <= 3; g++) begin
      wait_idle(g, ok);
      checks++; if (sclk_a[g] !== 1'(CPOL_A[g])) begin errors++; $display("FAIL mode%0d_idle_sclk got %b exp %0d", g, sclk_a[g], CPOL_A[g]); end
      run_xfer(g, 3'd1, 16'h8001, lat);
      checks++; if (d_a[g] !== 16'h8001) begin errors++; $display("FAIL mode%0d_data got %h exp 8001", g, d_a[g]); end
      checks++; if (edg_a[g] !== 32'd32) begin errors++; $display("FAIL mode%0d_edges got %0d exp 32", g, edg_a[g]); end
      checks++; if (sclk_a[g] !== 1'(CPOL_A[g])) begin errors++; $display("FAIL mode%0d_end_sclk got %b exp %0d", g, sclk_a[g], CPOL_A[g]); end
      @(negedge clk);
      rd_a[g] = 1'b0;
    end
  endtask

  task automatic test_chsel;
    bit ok;
    bit seen_busy;
    bit seen_cs;
    int c0;
    int lat;
    wait_idle(0, ok);
    word_a[0] = 16'h3C96;
    ch_a[0]   = 3'd2;
    rd_a[0]   = 1'b1;
    @(negedge clk);
    ch_a[0] = 3'd0;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (csn_a[0] !== 4'b1011) begin errors++; $display("FAIL ch2_cs_n got %b exp 1011", csn_a[0]); end
    checks++; if (busy_a[0] !== 1'b1) begin errors++; $display("FAIL ch2_busy got %b exp 1", busy_a[0]); end
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (drdy_a[0] === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++; if (lat < 0) begin errors++; $display("FAIL ch2_done got timeout exp d_ready"); end
    checks++; if (d_a[0] !== 16'h3C96) begin errors++; $display("FAIL ch2_data got %h exp 3c96", d_a[0]); end
    @(negedge clk);
    rd_a[0] = 1'b0;
    wait_idle(0, ok);
    c0 = int'(csf_a[0]);
    seen_busy = 1'b0;
    seen_cs   = 1'b0;
    ch_a[0] = 3'd5;
    rd_a[0] = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (busy_a[0] !== 1'b0) seen_busy = 1'b1;
      if (csn_a[0] !== 4'hF) seen_cs = 1'b1;
    end
    checks++; if (seen_busy) begin errors++; $display("FAIL ch5_busy got 1 exp 0"); end
    checks++; if (seen_cs) begin errors++; $display("FAIL ch5_cs_n got active exp all high"); end
    checks++; if (int'(csf_a[0]) != c0) begin errors++; $display("FAIL ch5_transfers got %0d exp 0", int'(csf_a[0]) - c0); end
    @(negedge clk);
    rd_a[0] = 1'b0;
    ch_a[0] = 3'd0;
  endtask

  task automatic test_back_to_back;
    bit ok;
    bit dropped;
    int lat;
    int gap;
    wait_idle(0, ok);
    run_xfer(0, 3'd0, 16'h1234, lat);
    checks++; if (lat < 0) begin errors++; $display("FAIL b2b_first got timeout exp d_ready"); end
    dropped = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (drdy_a[0] !== 1'b1) dropped = 1'b1;
    end
    checks++; if (dropped) begin errors++; $display("FAIL b2b_drdy_hold got dropped exp held"); end
    checks++; if (d_a[0] !== 16'h1234) begin errors++; $display("FAIL b2b_first_data got %h exp 1234", d_a[0]); end
    @(negedge clk);
    word_a[0] = 16'h0F0F;
    rd_a[0]   = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (drdy_a[0] !== 1'b0) begin errors++; $display("FAIL b2b_drdy_drop got %b exp 0", drdy_a[0]); end
    checks++; if (busy_a[0] !== 1'b1) begin errors++; $display("FAIL b2b_guard_busy got %b exp 1", busy_a[0]); end
    @(negedge clk);
    rd_a[0] = 1'b1;
    gap = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (csn_a[0] !== 4'hF) begin
        gap = i;
        break;
      end
    end
    checks++; if (gap < 9 || gap > 14) begin errors++; $display("FAIL b2b_guard_gap got %0d exp 10..13", gap); end
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (drdy_a[0] === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++; if (d_a[0] !== 16'h0F0F || lat < 0) begin errors++; $display("FAIL b2b_second_data got %h exp 0f0f", d_a[0]); end
    @(negedge clk);
    rd_a[0] = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit hit;
    wait_idle(0, ok);
    word_a[0] = 16'h5A5A;
    rd_a[0]   = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (csn_a[0] !== 4'hF) begin
        hit = 1'b1;
        break;
      end
    end
    for (int i = 0; i < 200 && hit; i++) begin
      @(negedge clk);
      #1;
      if (edg_a[0] >= 32'd17) break;
    end
    checks++; if (!hit || sclk_a[0] !== 1'b1) begin errors++; $display("FAIL rmid_reach got sclk=%b exp 1 mid-shift", sclk_a[0]); end
    rst_l = 1'b0;
    #1;
    checks++; if (csn_a[0] !== 4'hF) begin errors++; $display("FAIL rmid_cs_n got %h exp f", csn_a[0]); end
    checks++; if (sclk_a[0] !== 1'b0) begin errors++; $display("FAIL rmid_sclk got %b exp 0", sclk_a[0]); end
    checks++; if (d_a[0] !== 16'h0) begin errors++; $display("FAIL rmid_d got %h exp 0", d_a[0]); end
    checks++; if (drdy_a[0] !== 1'b0) begin errors++; $display("FAIL rmid_drdy got %b exp 0", drdy_a[0]); end
    rd_a[0] = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    repeat (GHP * DIV - 1) @(posedge clk);
    #1;
    checks++; if (busy_a[0] !== 1'b1) begin errors++; $display("FAIL rmid_guard got busy=%b exp 1", busy_a[0]); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy_a[0] !== 1'b0) begin errors++; $display("FAIL rmid_idle got busy=%b exp 0", busy_a[0]); end
  endtask

  task automatic test_drop_rd;
    bit          ok;
    bit          hit;
    int          c0;
    int          hi;
    logic [15:0] dv;
    wait_idle(4, ok);
    c0 = int'(csf_a[4]);
    word_a[4] = 16'h0FFF;
    ch_a[4]   = 3'd0;
    rd_a[4]   = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (csn_a[4] !== 4'hF) begin
        hit = 1'b1;
        break;
      end
    end
    for (int i = 0; i < 200 && hit; i++) begin
      @(negedge clk);
      #1;
      if (edg_a[4] >= 32'd6) break;
    end
    rd_a[4] = 1'b0;
    hi = 0;
    dv = 16'hDEAD;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (drdy_a[4] === 1'b1) begin
        hi++;
        dv = d_a[4];
      end
    end
    checks++; if (hi != 1) begin errors++; $display("FAIL drop_pulse got %0d clks exp 1", hi); end
    checks++; if (dv !== 16'h0FFF) begin errors++; $display("FAIL drop_data got %h exp 0fff", dv); end
    checks++; if (int'(csf_a[4]) - c0 != 1) begin errors++; $display("FAIL drop_transfers got %0d exp 1", int'(csf_a[4]) - c0); end
    checks++; if (busy_a[4] !== 1'b0) begin errors++; $display("FAIL drop_end_busy got %b exp 0", busy_a[4]); end
  endtask

  initial begin
    for (int g = 0; g < NI; g++) begin
      rd_a[g]   = 1'b0;
      ch_a[g]   = 3'd0;
      word_a[g] = 16'h0;
    end
    test_reset();
    test_mode0();
    test_modes();
    test_chsel();
    test_back_to_back();
    test_reset_mid();
    test_drop_rd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
